// File: rtl/cop_issue.sv
// cop_issue: issue/transfer front end between the integer core
// and the floating-point coprocessor (arith issue, lws, sws).
module cop_issue (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_instr_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_base_val,
    output logic        o_instr_ready,
    output logic        o_done,
    output logic        o_illegal,
    output logic [5:0]  o_cop_opcode,
    output logic [4:0]  o_cop_rs,
    output logic [4:0]  o_cop_rt,
    output logic [4:0]  o_cop_rd,
    output logic [31:0] o_cop_wdata,
    input  logic [31:0] i_cop_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_LWS = 6'b110111;
    localparam logic [5:0] OP_SWS = 6'b111000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LW_MEM,
        S_LW_WRITE,
        S_SW_READ,
        S_SW_CAPTURE,
        S_SW_MEM,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_op;
    logic [4:0]  r_fs;
    logic        r_illegal;
    logic [31:0] r_addr;
    logic [4:0]  r_cop_rs;
    logic [4:0]  r_cop_rt;
    logic [4:0]  r_cop_rd;
    logic [31:0] r_cop_wdata;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic [5:0]  w_op;
    logic        w_arith;
    logic        w_lws;
    logic        w_sws;
    logic [31:0] w_offset;

    assign w_accept = i_instr_valid && (r_state == S_IDLE);
    assign w_op     = i_instr[31:26];
    assign w_arith  = (w_op >= OP_ADD) && (w_op <= OP_RND);
    assign w_lws    = (w_op == OP_LWS);
    assign w_sws    = (w_op == OP_SWS);
    assign w_offset = {{16{i_instr[15]}}, i_instr[15:0]};

    // State register; reset drops any in-flight instruction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_arith)    w_next = S_ISSUE;
                    else if (w_lws) w_next = S_LW_MEM;
                    else if (w_sws) w_next = S_SW_READ;
                    else            w_next = S_DONE;
                end
            end
            S_ISSUE:      w_next = S_DONE;
            S_LW_MEM:     if (i_mem_ack) w_next = S_LW_WRITE;
            S_LW_WRITE:   w_next = S_DONE;
            S_SW_READ:    w_next = S_SW_CAPTURE;
            S_SW_CAPTURE: w_next = S_SW_MEM;
            S_SW_MEM:     if (i_mem_ack) w_next = S_DONE;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    // Latch instruction fields and drive the held coprocessor/memory data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op        <= OP_NOP;
            r_fs        <= '0;
            r_illegal   <= 1'b0;
            r_addr      <= '0;
            r_cop_rs    <= '0;
            r_cop_rt    <= '0;
            r_cop_rd    <= '0;
            r_cop_wdata <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= w_op;
                r_fs      <= i_instr[25:21];
                r_illegal <= !(w_arith || w_lws || w_sws);
                r_addr    <= i_base_val + w_offset;
                if (w_arith) begin
                    r_cop_rs <= i_instr[25:21];
                    r_cop_rt <= i_instr[20:16];
                    r_cop_rd <= i_instr[15:11];
                end
                if (w_sws) begin
                    r_cop_rs <= i_instr[25:21];
                end
            end
            if (r_state == S_LW_MEM && i_mem_ack) begin
                r_cop_rs    <= r_fs;
                r_cop_wdata <= i_mem_rdata;
            end
            if (r_state == S_SW_CAPTURE) begin
                r_mem_wdata <= i_cop_rdata;
            end
        end
    end

    // Moore output decode; opcode is NOP outside the issue states.
    always_comb begin
        o_cop_opcode = OP_NOP;
        case (r_state)
            S_ISSUE:    o_cop_opcode = r_op;
            S_LW_WRITE: o_cop_opcode = OP_LWS;
            S_SW_READ:  o_cop_opcode = OP_SWS;
            default:    o_cop_opcode = OP_NOP;
        endcase
    end

    assign o_instr_ready = (r_state == S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_illegal     = (r_state == S_DONE) && r_illegal;
    assign o_mem_req     = (r_state == S_LW_MEM) || (r_state == S_SW_MEM);
    assign o_mem_we      = (r_state == S_SW_MEM);
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_cop_rs      = r_cop_rs;
    assign o_cop_rt      = r_cop_rt;
    assign o_cop_rd      = r_cop_rd;
    assign o_cop_wdata   = r_cop_wdata;

endmodule

// File: tb/tb_cop_issue.sv
// tb_cop_issue: directed scoreboard bench for cop_issue.
// Expected coprocessor/memory traffic is queued at drive time.
module tb_cop_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_instr_valid;
    logic [31:0] i_instr;
    logic [31:0] i_base_val;
    logic        o_instr_ready;
    logic        o_done;
    logic        o_illegal;
    logic [5:0]  o_cop_opcode;
    logic [4:0]  o_cop_rs;
    logic [4:0]  o_cop_rt;
    logic [4:0]  o_cop_rd;
    logic [31:0] o_cop_wdata;
    logic [31:0] i_cop_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    cop_issue dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr_valid (i_instr_valid),
        .i_instr       (i_instr),
        .i_base_val    (i_base_val),
        .o_instr_ready (o_instr_ready),
        .o_done        (o_done),
        .o_illegal     (o_illegal),
        .o_cop_opcode  (o_cop_opcode),
        .o_cop_rs      (o_cop_rs),
        .o_cop_rt      (o_cop_rt),
        .o_cop_rd      (o_cop_rd),
        .o_cop_wdata   (o_cop_wdata),
        .i_cop_rdata   (i_cop_rdata),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_ack     (i_mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] wd;
        bit          chk_rtrd;
        bit          chk_wd;
    } cop_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } mem_t;

    cop_t cq[$];
    mem_t mq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ar(input logic [5:0] op,
            input logic [4:0] fs, input logic [4:0] ft, input logic [4:0] fd);
        return {op, fs, ft, fd, 11'd0};
    endfunction

    function automatic logic [31:0] mk_ls(input logic [5:0] op,
            input logic [4:0] fs, input logic [15:0] off);
        return {op, fs, 5'd0, off};
    endfunction

    function automatic logic [31:0] ea(input logic [31:0] base,
            input logic [15:0] off);
        return base + {{16{off[15]}}, off};
    endfunction

    task automatic push_ar(input logic [5:0] op, input logic [4:0] fs,
            input logic [4:0] ft, input logic [4:0] fd);
        cop_t e;
        e.op = op; e.rs = fs; e.rt = ft; e.rd = fd;
        e.wd = '0; e.chk_rtrd = 1'b1; e.chk_wd = 1'b0;
        cq.push_back(e);
    endtask

    task automatic push_ls(input logic [5:0] op, input logic [4:0] fs,
            input logic [31:0] wd, input bit cw);
        cop_t e;
        e.op = op; e.rs = fs; e.rt = '0; e.rd = '0;
        e.wd = wd; e.chk_rtrd = 1'b0; e.chk_wd = cw;
        cq.push_back(e);
    endtask

    // Offer one instruction; returns just after the accept edge.
    task automatic drive(input logic [31:0] ins, input logic [31:0] base);
        i_instr_valid = 1'b1;
        i_instr       = ins;
        i_base_val    = base;
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0;
    endtask

    // Wait (bounded) for a coprocessor transfer and score it.
    task automatic wait_cop(input string tag, input int budget,
            input int exp_lat);
        cop_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_cop_opcode == 6'd0 && n < budget);
        if (o_cop_opcode == 6'd0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=none expected=transfer", tag);
        end else if (cq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_unexpected observed=%h expected=none",
                   tag, o_cop_opcode);
        end else begin
            e = cq.pop_front();
            chk({tag, "_op"}, 32'(o_cop_opcode), 32'(e.op));
            chk({tag, "_rs"}, 32'(o_cop_rs), 32'(e.rs));
            if (e.chk_rtrd) begin
                chk({tag, "_rt"}, 32'(o_cop_rt), 32'(e.rt));
                chk({tag, "_rd"}, 32'(o_cop_rd), 32'(e.rd));
            end
            if (e.chk_wd) chk({tag, "_wdata"}, o_cop_wdata, e.wd);
            chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
            chk({tag, "_nomem"}, 32'(o_mem_req), 32'd0);
        end
    endtask

    // Score the memory request visible now against the queue head.
    task automatic score_mem(input string tag, input logic we);
        mem_t m;
        chk({tag, "_req"}, 32'(o_mem_req), 32'd1);
        chk({tag, "_we"}, 32'(o_mem_we), 32'(we));
        if (mq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_unexpected observed=%h expected=none",
                   tag, o_mem_addr);
        end else begin
            m = mq.pop_front();
            chk({tag, "_addr"}, o_mem_addr, m.addr);
            if (we) chk({tag, "_wdata"}, o_mem_wdata, m.data);
        end
    endtask

    task automatic done_chk(input string tag, input logic ill);
        @(negedge clk);
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_illegal"}, 32'(o_illegal), 32'(ill));
        chk({tag, "_nop"}, 32'(o_cop_opcode), 32'd0);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(o_done), 32'd0);
        chk({tag, "_ready"}, 32'(o_instr_ready), 32'd1);
    endtask

    initial begin
        mem_t m;
        int   reqc;
        int   dn;
        int   t_a;
        int   t_b;

        rst           = 1'b1;
        i_instr_valid = 1'b0;
        i_instr       = '0;
        i_base_val    = '0;
        i_cop_rdata   = '0;
        i_mem_rdata   = '0;
        i_mem_ack     = 1'b0;

        // reset values
        #2;
        chk("rst_ready", 32'(o_instr_ready), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_illegal", 32'(o_illegal), 32'd0);
        chk("rst_op", 32'(o_cop_opcode), 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_we", 32'(o_mem_we), 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_mwdata", o_mem_wdata, 32'd0);
        chk("rst_cwdata", o_cop_wdata, 32'd0);
        chk("rst_rs", 32'(o_cop_rs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // add fs=1 ft=2 fd=3
        push_ar(6'b110000, 5'd1, 5'd2, 5'd3);
        drive(mk_ar(6'b110000, 5'd1, 5'd2, 5'd3), 32'd0);
        wait_cop("add", 1, 1);
        done_chk("add", 1'b0);

        // lws with two wait cycles
        push_ls(6'b110111, 5'd4, 32'h40490FDB, 1'b1);
        m.addr = ea(32'h100, 16'hFFFC);
        m.data = '0;
        mq.push_back(m);
        drive(mk_ls(6'b110111, 5'd4, 16'hFFFC), 32'h100);
        reqc = 0;
        @(negedge clk);
        score_mem("lw", 1'b0);
        chk("lw_addr_abs", o_mem_addr, 32'h000000FC);
        chk("lw_wait_nop", 32'(o_cop_opcode), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (o_mem_req) reqc++;
        end
        i_mem_rdata = 32'h40490FDB;
        i_mem_ack   = 1'b1;
        @(posedge clk);
        #1;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'hDEADBEEF;
        chk("lw_req_cycles", 32'(reqc), 32'd3);
        wait_cop("lw", 1, 1);
        done_chk("lw", 1'b0);

        // sws fs=5, coprocessor returns 1.0f
        push_ls(6'b111000, 5'd5, 32'd0, 1'b0);
        m.addr = ea(32'h8000_0000, 16'h0024);
        m.data = 32'h3F800000;
        mq.push_back(m);
        drive(mk_ls(6'b111000, 5'd5, 16'h0024), 32'h8000_0000);
        t_a = cyc;
        wait_cop("sw", 1, 1);
        @(posedge clk);
        #1;
        i_cop_rdata = 32'h3F800000;
        @(negedge clk);
        chk("sw_capture_noreq", 32'(o_mem_req), 32'd0);
        @(posedge clk);
        #1;
        i_cop_rdata = 32'h0BADF00D;
        @(negedge clk);
        score_mem("sw", 1'b1);
        i_mem_ack = 1'b1;
        @(posedge clk);
        #1;
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk("sw_done_lat", 32'(cyc - t_a), 32'd3);
        chk("sw_done", 32'(o_done), 32'd1);
        chk("sw_done_illegal", 32'(o_illegal), 32'd0);
        @(negedge clk);
        chk("sw_ready", 32'(o_instr_ready), 32'd1);

        // illegal opcode 000111
        drive(mk_ar(6'b000111, 5'd9, 5'd9, 5'd9), 32'h1234);
        @(negedge clk);
        chk("ill_done", 32'(o_done), 32'd1);
        chk("ill_flag", 32'(o_illegal), 32'd1);
        chk("ill_op", 32'(o_cop_opcode), 32'd0);
        chk("ill_req", 32'(o_mem_req), 32'd0);
        @(negedge clk);
        chk("ill_done_low", 32'(o_done), 32'd0);
        chk("ill_flag_low", 32'(o_illegal), 32'd0);
        chk("ill_ready", 32'(o_instr_ready), 32'd1);

        // back-to-back with valid held: mul then rnd, 3-cycle spacing
        push_ar(6'b110010, 5'd7, 5'd8, 5'd9);
        push_ar(6'b110110, 5'd31, 5'd0, 5'd17);
        i_instr_valid = 1'b1;
        i_instr       = mk_ar(6'b110010, 5'd7, 5'd8, 5'd9);
        @(posedge clk);
        #1;
        i_instr = mk_ar(6'b110110, 5'd31, 5'd0, 5'd17);
        wait_cop("mul", 1, 1);
        t_a = cyc;
        @(negedge clk);
        chk("b2b_done", 32'(o_done), 32'd1);
        chk("b2b_busy", 32'(o_instr_ready), 32'd0);
        @(negedge clk);
        chk("b2b_idle_nop", 32'(o_cop_opcode), 32'd0);
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0;
        wait_cop("rnd", 4, 1);
        t_b = cyc;
        chk("b2b_spacing", 32'(t_b - t_a), 32'd3);
        done_chk("rnd", 1'b0);

        // reset while in LW_MEM drops the load
        push_ls(6'b110111, 5'd6, 32'h12345678, 1'b1);
        drive(mk_ls(6'b110111, 5'd6, 16'h0010), 32'h2000);
        @(negedge clk);
        chk("rlw_req", 32'(o_mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rlw_req_async", 32'(o_mem_req), 32'd0);
        chk("rlw_ready_async", 32'(o_instr_ready), 32'd1);
        #1;
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_done) dn++;
        end
        chk("rlw_no_done", 32'(dn), 32'd0);
        chk("rlw_no_req", 32'(o_mem_req), 32'd0);

        // next lws completes normally with zero wait
        m.addr = ea(32'h2000, 16'h0010);
        m.data = '0;
        mq.push_back(m);
        drive(mk_ls(6'b110111, 5'd6, 16'h0010), 32'h2000);
        @(negedge clk);
        score_mem("lw2", 1'b0);
        i_mem_rdata = 32'h12345678;
        i_mem_ack   = 1'b1;
        @(posedge clk);
        #1;
        i_mem_ack   = 1'b0;
        wait_cop("lw2", 1, 1);
        done_chk("lw2", 1'b0);

        chk("cop_queue_empty", 32'(cq.size()), 32'd0);
        chk("mem_queue_empty", 32'(mq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
